// File: rtl/func_child_adapter.sv
// Call/return adapter between the function arbiter and one HLS-generated child function.
// Optional macro FUNC_CHILD_RET_SKID_EN adds a one-entry return holding register (result plus context).
module func_child_adapter #(
    parameter int LOG_THREAD = 4,
    parameter int LOG_PARENT = 5,
    parameter int LOG_SEQ    = 3,
    parameter int ARG_W      = 32,
    parameter int ARG_NUM    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     callVld_i,
    output logic                     rdy_o,
    input  logic [1:0]               retReq_i,
    input  logic [LOG_THREAD-1:0]    thread_i,
    input  logic [LOG_PARENT-1:0]    parent_i,
    input  logic [ARG_W-1:0]         pc_i,
    input  logic [ARG_NUM*ARG_W-1:0] args_i,
    input  logic [LOG_SEQ-1:0]       callSeq_i,
    output logic                     hls_start_o,
    input  logic                     hls_ready_i,
    input  logic                     hls_done_i,
    input  logic [31:0]              hls_return_i,
    output logic [ARG_W-1:0]         hls_pc_o,
    output logic [ARG_NUM*ARG_W-1:0] hls_args_o,
    output logic                     retVld_o,
    input  logic                     retRdy_i,
    output logic [31:0]              retDin_o,
    output logic [LOG_THREAD-1:0]    retThread_o,
    output logic [LOG_PARENT-1:0]    parentMod_o,
    output logic [LOG_SEQ-1:0]       retSeq_o,
    output logic                     retMode_o,
    output logic                     protocol_err_o
);
    localparam int RET_W = 32 + LOG_THREAD + LOG_PARENT + LOG_SEQ + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2, S_RET = 2'd3} state_t;
    state_t state_q, state_d, done_next;

    logic [LOG_THREAD-1:0]    thread_q;
    logic [LOG_PARENT-1:0]    parent_q;
    logic [LOG_SEQ-1:0]       seq_q;
    logic [1:0]               req_q;
    logic [ARG_W-1:0]         pc_q;
    logic [ARG_NUM*ARG_W-1:0] args_q;
    logic [31:0]              result_q;
    logic                     err_q;
    logic                     accept, done_evt, err_evt;

    assign accept  = callVld_i & (state_q == S_IDLE);
    assign err_evt = (callVld_i & (state_q != S_IDLE)) |
                     (hls_done_i & ((state_q == S_IDLE) | ((state_q == S_START) & ~hls_ready_i)));

`ifdef FUNC_CHILD_RET_SKID_EN
    logic             skid_vld_q, pend_q, skid_free;
    logic [RET_W-1:0] skid_q;

    // The holding register counts as free in the cycle its handshake completes.
    assign skid_free = ~skid_vld_q | retRdy_i;
    assign done_evt  = ((state_q == S_START) & hls_ready_i & hls_done_i) |
                       ((state_q == S_RUN) & ~pend_q & hls_done_i);
    assign done_next = (~req_q[0] | skid_free) ? S_IDLE : S_RUN;
`else
    assign done_evt  = ((state_q == S_START) & hls_ready_i & hls_done_i) |
                       ((state_q == S_RUN) & hls_done_i);
    assign done_next = req_q[0] ? S_RET : S_IDLE;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (callVld_i) state_d = S_START;
            S_START: if (hls_ready_i) state_d = hls_done_i ? done_next : S_RUN;
            S_RUN: begin
`ifdef FUNC_CHILD_RET_SKID_EN
                if (pend_q) begin
                    if (skid_free) state_d = S_IDLE;
                end else
`endif
                if (hls_done_i) state_d = done_next;
            end
            S_RET:   if (retRdy_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            thread_q <= '0;
            parent_q <= '0;
            seq_q    <= '0;
            req_q    <= '0;
            pc_q     <= '0;
            args_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_evt) err_q <= 1'b1;
            if (accept) begin
                thread_q <= thread_i;
                parent_q <= parent_i;
                seq_q    <= callSeq_i;
                req_q    <= retReq_i;
                pc_q     <= pc_i;
                args_q   <= args_i;
            end
            if (done_evt) result_q <= hls_return_i;
        end
    end

`ifdef FUNC_CHILD_RET_SKID_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            skid_q     <= '0;
        end else begin
            if (done_evt & req_q[0] & skid_free) begin
                skid_q     <= {hls_return_i, thread_q, parent_q, seq_q, req_q[1]};
                skid_vld_q <= 1'b1;
            end else if (pend_q & skid_free) begin
                skid_q     <= {result_q, thread_q, parent_q, seq_q, req_q[1]};
                skid_vld_q <= 1'b1;
            end else if (retRdy_i) begin
                skid_vld_q <= 1'b0;
            end
            if (done_evt & req_q[0] & ~skid_free) pend_q <= 1'b1;
            else if (pend_q & skid_free)         pend_q <= 1'b0;
        end
    end

    assign retVld_o = skid_vld_q;
    assign {retDin_o, retThread_o, parentMod_o, retSeq_o, retMode_o} = skid_q;
`else
    assign retVld_o = (state_q == S_RET);
    assign {retDin_o, retThread_o, parentMod_o, retSeq_o, retMode_o} =
        RET_W'({result_q, thread_q, parent_q, seq_q, req_q[1]});
`endif

    assign rdy_o          = (state_q == S_IDLE);
    assign hls_start_o    = (state_q == S_START);
    assign hls_pc_o       = pc_q;
    assign hls_args_o     = args_q;
    assign protocol_err_o = err_q;
endmodule

// File: tb/tb_func_child_adapter.sv
// Randomized self-checking bench for func_child_adapter; return transactions scored against an expected queue.
// Also covers the FUNC_CHILD_RET_SKID_EN build when that macro is defined.
module tb_func_child_adapter;
    localparam int LT = 4, LP = 5, LS = 3, AW = 32, AN = 8;
    localparam int RW = 32 + LT + LP + LS + 1;
`ifdef FUNC_CHILD_RET_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk, rstn, callVld_i, rdy_o, hls_start_o, hls_ready_i, hls_done_i;
    logic retVld_o, retRdy_i, retMode_o, protocol_err_o;
    logic [1:0] retReq_i;
    logic [LT-1:0] thread_i, retThread_o;
    logic [LP-1:0] parent_i, parentMod_o;
    logic [LS-1:0] callSeq_i, retSeq_o;
    logic [AW-1:0] pc_i, hls_pc_o;
    logic [AN*AW-1:0] args_i, hls_args_o;
    logic [31:0] hls_return_i, retDin_o;

    func_child_adapter dut (
        .clk(clk), .rstn(rstn), .callVld_i(callVld_i), .rdy_o(rdy_o), .retReq_i(retReq_i),
        .thread_i(thread_i), .parent_i(parent_i), .pc_i(pc_i), .args_i(args_i),
        .callSeq_i(callSeq_i), .hls_start_o(hls_start_o), .hls_ready_i(hls_ready_i),
        .hls_done_i(hls_done_i), .hls_return_i(hls_return_i), .hls_pc_o(hls_pc_o),
        .hls_args_o(hls_args_o), .retVld_o(retVld_o), .retRdy_i(retRdy_i), .retDin_o(retDin_o),
        .retThread_o(retThread_o), .parentMod_o(parentMod_o), .retSeq_o(retSeq_o),
        .retMode_o(retMode_o), .protocol_err_o(protocol_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [RW-1:0] exp_q[$];
    logic exp_err = 1'b0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_rdy", rdy_o, 1);
        check("rst_start", hls_start_o, 0);
        check("rst_vld", retVld_o, 0);
        check("rst_err", protocol_err_o, 0);
        check("rst_ret", {retDin_o, retThread_o, parentMod_o, retSeq_o, retMode_o}, 0);
        check("rst_pc", hls_pc_o, 0);
        check("rst_args", hls_args_o, 0);
    endtask

    task automatic check_ret(input logic [RW-1:0] e);
        check("ret_vld", retVld_o, 1);
        check("ret_din", retDin_o, e[RW-1 -: 32]);
        check("ret_thread", retThread_o, e[LP+LS+LT : LP+LS+1]);
        check("ret_parent", parentMod_o, e[LP+LS : LS+1]);
        check("ret_seq", retSeq_o, e[LS:1]);
        check("ret_mode", retMode_o, e[0]);
    endtask

    task automatic drive_call(input logic [LT-1:0] th, input logic [LP-1:0] pa,
                              input logic [LS-1:0] sq, input logic [1:0] rq, input logic [31:0] val);
        callVld_i = 1'b1; thread_i = th; parent_i = pa; callSeq_i = sq; retReq_i = rq;
        pc_i = $urandom;
        for (int i = 0; i < AN; i++) args_i[i*AW +: AW] = $urandom;
        if (rq[0]) exp_q.push_back({val, th, pa, sq, rq[1]});
    endtask

    // One full call: accept, HLS handshake with given latencies, then return with bp cycles of backpressure.
    task automatic do_call(input logic [LT-1:0] th, input logic [LP-1:0] pa, input logic [LS-1:0] sq,
                           input logic [1:0] rq, input logic [31:0] val, input int lat_r,
                           input int lat_d, input int bp, input bit inject, input bit bad_done);
        logic [AW-1:0] pc;
        logic [AN*AW-1:0] args;
        logic [RW-1:0] e;
        check("idle_rdy", rdy_o, 1);
        drive_call(th, pa, sq, rq, val);
        pc = pc_i; args = args_i;
        @(negedge clk);
        callVld_i = 1'b0; thread_i = $urandom; parent_i = $urandom; callSeq_i = $urandom;
        retReq_i = $urandom; pc_i = $urandom; args_i = {8{$urandom}};
        check("start", hls_start_o, 1);
        check("busy", rdy_o, 0);
        check("hls_pc", hls_pc_o, pc);
        check("hls_args", hls_args_o, args);
        for (int i = 0; i < lat_r; i++) begin
            hls_done_i = bad_done && (i == 0);
            if (bad_done && i == 0) exp_err = 1'b1;
            @(negedge clk);
            hls_done_i = 1'b0;
            check("start_hold", hls_start_o, 1);
        end
        hls_ready_i = 1'b1; hls_done_i = (lat_d == 0);
        hls_return_i = (lat_d == 0) ? val : $urandom;
        @(negedge clk);
        hls_ready_i = 1'b0; hls_done_i = 1'b0; hls_return_i = $urandom;
        if (lat_d > 0) begin
            for (int i = 1; i < lat_d; i++) begin
                check("run_wait", {hls_start_o, retVld_o, rdy_o}, 0);
                @(negedge clk);
            end
            hls_done_i = 1'b1; hls_return_i = val;
            @(negedge clk);
            hls_done_i = 1'b0; hls_return_i = $urandom;
        end
        check("hls_pc_hold", hls_pc_o, pc);
        if (rq[0]) begin
            e = exp_q.pop_front();
            check_ret(e);
            check("ret_rdy", rdy_o, SKID);
            for (int i = 0; i < bp; i++) begin
                if (inject && !SKID && i == bp / 2) begin
                    callVld_i = 1'b1; exp_err = 1'b1;
                end
                @(negedge clk);
                callVld_i = 1'b0;
                check_ret(e);
            end
            retRdy_i = 1'b1;
            @(negedge clk);
            retRdy_i = 1'b0;
            check("ret_done", retVld_o, 0);
            check("rdy_after_ret", rdy_o, 1);
        end else begin
            check("ff_novld", retVld_o, 0);
            check("ff_rdy", rdy_o, 1);
        end
        check("err", protocol_err_o, exp_err);
    endtask

    initial begin
        rstn = 1'b0; callVld_i = 1'b0; retReq_i = '0; thread_i = '0; parent_i = '0;
        pc_i = '0; args_i = '0; callSeq_i = '0; hls_ready_i = 1'b0; hls_done_i = 1'b0;
        hls_return_i = '0; retRdy_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rstn = 1'b1;
        @(negedge clk);

        do_call(4'd3, 5'd7, 3'd5, 2'b11, 32'hDEADBEEF, 1, 4, 0, 0, 0);
        do_call(4'd9, 5'd20, 3'd2, 2'b00, 32'h12345678, 2, 3, 0, 0, 0);
        do_call(4'd1, 5'd1, 3'd7, 2'b01, 32'd42, 0, 0, 0, 0, 0);
        do_call(4'd15, 5'd31, 3'd0, 2'b01, 32'hA5A5_0F0F, 1, 2, 10, 1, 0);

        // reset pulsed while the child is running
        drive_call(4'd6, 5'd6, 3'd6, 2'b11, 32'h0);
        exp_q.delete();
        @(negedge clk);
        callVld_i = 1'b0; hls_ready_i = 1'b1;
        @(negedge clk);
        hls_ready_i = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rstn = 1'b1; exp_err = 1'b0;
        @(negedge clk);
        do_call(4'd2, 5'd4, 3'd1, 2'b11, 32'h0BADF00D, 1, 1, 1, 0, 0);

        // stray done while idle
        hls_done_i = 1'b1; hls_return_i = $urandom;
        @(negedge clk);
        hls_done_i = 1'b0; exp_err = 1'b1;
        check("stray_done_err", protocol_err_o, 1);
        check("stray_done_rdy", rdy_o, 1);
        check("stray_done_vld", retVld_o, 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; exp_err = 1'b0;
        @(negedge clk);
        check("err_cleared", protocol_err_o, 0);

        for (int n = 0; n < 40; n++) begin
            do_call($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

`ifdef FUNC_CHILD_RET_SKID_EN
        // two back-to-back returning calls against a stalled return side
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; exp_err = 1'b0; exp_q.delete();
        @(negedge clk);
        begin
            logic [RW-1:0] ea, eb;
            drive_call(4'd3, 5'd7, 3'd5, 2'b11, 32'h1111_AAAA);
            @(negedge clk);
            callVld_i = 1'b0; hls_ready_i = 1'b1; hls_done_i = 1'b1; hls_return_i = 32'h1111_AAAA;
            @(negedge clk);
            hls_ready_i = 1'b0; hls_done_i = 1'b0;
            ea = exp_q.pop_front();
            check_ret(ea);
            check("skid_rdy_pending", rdy_o, 1);
            drive_call(4'd4, 5'd8, 3'd6, 2'b01, 32'h2222_BBBB);
            @(negedge clk);
            callVld_i = 1'b0;
            check("skid_start2", hls_start_o, 1);
            hls_ready_i = 1'b1; hls_done_i = 1'b1; hls_return_i = 32'h2222_BBBB;
            @(negedge clk);
            hls_ready_i = 1'b0; hls_done_i = 1'b0; hls_return_i = $urandom;
            for (int i = 0; i < 3; i++) begin
                check_ret(ea);
                check("skid_busy", rdy_o, 0);
                @(negedge clk);
            end
            retRdy_i = 1'b1;
            @(negedge clk);
            retRdy_i = 1'b0;
            eb = exp_q.pop_front();
            check_ret(eb);
            check("skid_rdy2", rdy_o, 1);
            retRdy_i = 1'b1;
            @(negedge clk);
            retRdy_i = 1'b0;
            check("skid_drained", retVld_o, 0);
            check("skid_err", protocol_err_o, 0);
        end
`endif

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/func_child_adapter.md
# func_child_adapter

Per-child call/return adapter between the function arbiter and one HLS-generated child function. It accepts a call from the arbiter's call side, latches the call context (thread, parent, sequence, return mode, pc, args), and runs the HLS `ap_start`/`ap_ready`/`ap_done` protocol. It then presents the result and context to the arbiter's return side on a valid/ready handshake. One instance sits at each child index `c`.

## Interface
Parameters:
- `LOG_THREAD`, 4, width of the thread id.
- `LOG_PARENT`, 5, width of the parent index.
- `LOG_SEQ`, 3, width of the call sequence number.
- `ARG_W`, 32, width of the pc and of each argument.
- `ARG_NUM`, 8, number of arguments.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `callVld_i` in 1: call strobe (bit `c` of the arbiter's `child_callVld_o`).
- `rdy_o` out 1: adapter can accept a call.
- `retReq_i` in 2: bit0 = return requested; bit1 = return mode (1 FIFO, 0 LIFO).
- `thread_i` in LOG_THREAD: caller thread.
- `parent_i` in LOG_PARENT: caller parent index.
- `pc_i` in ARG_W: call pc.
- `args_i` in ARG_NUM*ARG_W: call arguments.
- `callSeq_i` in LOG_SEQ: call sequence number.
- `hls_start_o` out 1: HLS `ap_start`.
- `hls_ready_i` in 1: HLS `ap_ready`.
- `hls_done_i` in 1: HLS `ap_done`.
- `hls_return_i` in 32: HLS `ap_return`.
- `hls_pc_o` out ARG_W: latched pc.
- `hls_args_o` out ARG_NUM*ARG_W: latched arguments.
- `retVld_o` out 1: result valid.
- `retRdy_i` in 1: return side accepts.
- `retDin_o` out 32: result.
- `retThread_o` out LOG_THREAD: returned thread.
- `parentMod_o` out LOG_PARENT: returned parent index.
- `retSeq_o` out LOG_SEQ: returned callSeq.
- `retMode_o` out 1: returned mode bit.
- `protocol_err_o` out 1: sticky protocol error flag.

## Operation
- FSM states:
  - IDLE: `rdy_o` = 1.
  - START: `hls_start_o` = 1.
  - RUN: waiting for `ap_done`.
  - RET: `retVld_o` = 1.
- Call accept: `callVld_i & rdy_o`. On accept, latch `thread_i`, `parent_i`, `pc_i`, `args_i`, `callSeq_i`, `retReq_i`; go to START.
- START:
  - Hold `hls_start_o` until `hls_ready_i`, then go to RUN.
  - If `hls_ready_i` and `hls_done_i` are high in the same cycle, treat the call as done immediately.
- RUN: on `hls_done_i`, capture `hls_return_i` into the result register.
  - If `retReq[0]` = 1, go to RET.
  - If `retReq[0]` = 0, go to IDLE (fire-and-forget; no return is issued).
- RET: `retVld_o` and all `ret*` outputs stay stable until `retRdy_i`; then go to IDLE.
- `retSeq_o` = latched `callSeq`. `retMode_o` = latched `retReq[1]`. `parentMod_o` = latched parent index.
- `hls_pc_o` and `hls_args_o` hold their latched values until the next accept.
- `callVld_i` while `rdy_o` = 0: the call is ignored, and `protocol_err_o` is set and stays set until reset.
- `hls_done_i` seen in IDLE or START (without `hls_ready_i`): ignored, `protocol_err_o` set.
- Reset mid-operation: FSM returns to IDLE and the in-flight call is discarded.

## Timing
- Reset values:
  - `rdy_o` = 1.
  - `hls_start_o` = 0.
  - `retVld_o` = 0.
  - `protocol_err_o` = 0.
  - All data and context outputs = 0.
- Accept in cycle N → `hls_start_o` = 1 in N+1; `rdy_o` = 0 from N+1.
- `hls_done_i` in cycle D → `retVld_o` = 1 in D+1, with `retDin_o` = `hls_return_i` sampled at D.
- Handshake completes in a cycle where `retVld_o & retRdy_i` → `rdy_o` = 1 in the next cycle. Minimum call-to-call spacing is therefore return accept + 1.
- Fire-and-forget: done in cycle D → `rdy_o` = 1 in D+1.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `FUNC_CHILD_RET_SKID_EN`.
- Defined: adds a one-entry return holding register (result plus context).
  - On done with return requested, the entry moves to the holding register and the FSM returns to IDLE in D+1, so `rdy_o` = 1 while `retVld_o` is still pending.
  - If a second done arrives while the register is still occupied, the FSM stays in RUN (done held internally) until the register drains, then loads it in the cycle it frees.
- Not defined: no holding register; behaviour exactly as in Operation.

## Test plan
- Call: thread 3, parent 7, callSeq 5, retReq 2'b11; HLS returns `0xDEADBEEF` 4 cycles after ready, `retRdy_i` tied 1 → `retVld_o` pulses 1 cycle with `retDin_o` = `0xDEADBEEF`, `retThread_o` = 3, `parentMod_o` = 7, `retSeq_o` = 5, `retMode_o` = 1; `rdy_o` rises the next cycle.
- retReq 2'b00 call → `retVld_o` never asserts; `rdy_o` = 1 in the cycle after `hls_done_i`.
- `retRdy_i` held 0 for 10 cycles after done → `retVld_o` and all `ret*` outputs stable for all 10 cycles; a `callVld_i` injected during this window is ignored and `protocol_err_o` = 1.
- `hls_ready_i` and `hls_done_i` asserted in the same cycle as the first `hls_start_o` (`ap_return` = 42) → `retVld_o` = 1 the next cycle with `retDin_o` = 42.
- `rstn` pulsed low during RUN → all outputs return to reset values and `rdy_o` = 1; the next call completes normally.
- With `FUNC_CHILD_RET_SKID_EN`: `retRdy_i` = 0 and two back-to-back returning calls → `rdy_o` = 1 while the first return is pending; the second result is presented only after the first handshake, in call order.
